// File: rtl/hack_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// hack_fetch_unit_if
//   Bundles the ROM port, jump redirect and output handshake of the Hack
//   fetch stage. clk/reset are not part of the bundle.
//
//   rom_addr    : fetch -> ROM, address (equals PC)
//   rom_instr   : ROM -> fetch, combinational read data
//   jump_en     : execute -> fetch, redirect request
//   jump_addr   : execute -> fetch, redirect target
//   out_valid   : fetch -> decode, entry is live
//   out_ready   : decode -> fetch, entry accepted this cycle
//   out_instr   : fetch -> decode, captured instruction
//   out_pc      : fetch -> decode, address of out_instr
//   fetch_count : completed handshakes (wraps)
//   fault       : sticky out-of-bounds fetch flag
//
//   master : the fetch unit side; slave : the environment side.
// ---------------------------------------------------------------------------
interface hack_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_instr;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [15:0]       fetch_count;
  logic              fault;

  modport master (
    output rom_addr, out_valid, out_instr, out_pc, fetch_count, fault,
    input  rom_instr, jump_en, jump_addr, out_ready
  );

  modport slave (
    input  rom_addr, out_valid, out_instr, out_pc, fetch_count, fault,
    output rom_instr, jump_en, jump_addr, out_ready
  );
endinterface

// File: rtl/hack_fetch_unit.sv
// ---------------------------------------------------------------------------
// hack_fetch_unit
//   Instruction fetch stage for the Hack CPU. Owns the PC, addresses the
//   combinational instruction ROM, captures {instr, pc} into an output
//   register and hands it downstream with valid/ready. A jump from execute
//   redirects the PC and flushes the captured entry.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : hack_fetch_unit_if.master (ROM port, jump, handshake, status)
//
//   Optional feature, macro FETCH_BOUNDS_EN:
//     When defined, a capture from pc >= ROM_DEPTH is refused, fault is set
//     and the unit enters HALT (jumps ignored, pc frozen, any pending entry
//     drains, then out_valid stays low until reset). When undefined, there
//     is no bounds check and fault is constant 0.
// ---------------------------------------------------------------------------
module hack_fetch_unit #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 16,
  parameter int                ROM_DEPTH = 256,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  hack_fetch_unit_if.master bus
);

`ifdef FETCH_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] opc_q, opc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              fault_q, fault_d;

  logic consume;
  logic oob;

  assign consume = valid_q & bus.out_ready;
  // Widen before comparing so a ROM_DEPTH of 2^ADDR_W never truncates.
  assign oob     = (32'(pc_q) >= 32'(ROM_DEPTH));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; all cleared by reset so outputs read zero at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    opc_d   = opc_q;
    fault_d = fault_q;
    // A consumption is counted even when a jump flushes on the same edge.
    cnt_d   = cnt_q + 16'(consume);

    case (state_q)
      RUN: begin
        if (bus.jump_en) begin
          pc_d    = bus.jump_addr;
          valid_d = 1'b0;
        end else if (!valid_q || bus.out_ready) begin
          if (BOUNDS_EN && oob) begin
            // Refused capture: any live entry was consumed this edge,
            // so nothing remains to present.
            fault_d = 1'b1;
            state_d = HALT;
            valid_d = 1'b0;
          end else begin
            instr_d = bus.rom_instr;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(1);
          end
        end
      end
      HALT: begin
        if (consume) begin
          valid_d = 1'b0;
        end
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.rom_addr    = pc_q;
    bus.out_valid   = valid_q;
    bus.out_instr   = instr_q;
    bus.out_pc      = opc_q;
    bus.fetch_count = cnt_q;
    bus.fault       = fault_q;
  end

endmodule

// File: tb/tb_hack_fetch_unit.sv
module tb_hack_fetch_unit;

`ifdef FETCH_BOUNDS_EN
  localparam bit M_BOUNDS = 1'b1;
`else
  localparam bit M_BOUNDS = 1'b0;
`endif
  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hack_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  hack_fetch_unit #(
    .ADDR_W(16), .DATA_W(16), .ROM_DEPTH(DEPTH), .RESET_PC(16'h0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] rom [0:65535];
  assign bus.rom_instr = rom[bus.rom_addr];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the architectural view of the fetch stage.
  logic [15:0] m_pc, m_ins, m_opc, m_cnt;
  logic        m_v, m_fault, m_halt;

  task automatic model_reset();
    m_pc = 16'h0000; m_v = 1'b0; m_ins = '0; m_opc = '0;
    m_cnt = '0; m_fault = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_step(input logic j, input logic [15:0] ja, input logic r);
    bit taken;
    taken = m_v && r;
    if (taken) m_cnt = m_cnt + 16'd1;
    if (m_halt) begin
      if (taken) m_v = 1'b0;
    end else if (j) begin
      m_pc = ja;
      m_v  = 1'b0;
    end else if (!m_v || r) begin
      if (M_BOUNDS && int'(m_pc) >= DEPTH) begin
        m_fault = 1'b1;
        m_halt  = 1'b1;
        m_v     = 1'b0;
      end else begin
        m_ins = rom[m_pc];
        m_opc = m_pc;
        m_v   = 1'b1;
        m_pc  = 16'((int'(m_pc) + 1) % 65536);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".rom_addr"},    32'(bus.rom_addr),    32'(m_pc));
    check({tag, ".out_valid"},   32'(bus.out_valid),   32'(m_v));
    if (m_v) begin
      check({tag, ".out_instr"}, 32'(bus.out_instr),   32'(m_ins));
      check({tag, ".out_pc"},    32'(bus.out_pc),      32'(m_opc));
    end
    check({tag, ".fetch_count"}, 32'(bus.fetch_count), 32'(m_cnt));
    check({tag, ".fault"},       32'(bus.fault),       32'(m_fault));
  endtask

  task automatic cycle(input logic j, input logic [15:0] ja, input logic r);
    bus.jump_en   = j;
    bus.jump_addr = ja;
    bus.out_ready = r;
    @(posedge clk);
    model_step(j, ja, r);
    #1;
  endtask

  // Async reset: outputs must clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst.rom_addr",    32'(bus.rom_addr),    32'h0);
    check("rst.out_valid",   32'(bus.out_valid),   32'h0);
    check("rst.out_instr",   32'(bus.out_instr),   32'h0);
    check("rst.out_pc",      32'(bus.out_pc),      32'h0);
    check("rst.fetch_count", 32'(bus.fetch_count), 32'h0);
    check("rst.fault",       32'(bus.fault),       32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        jump;
    logic [15:0] jaddr;
    logic        ready;
    logic        exp_v;
    logic [15:0] exp_pc;
    logic [15:0] exp_ins;
    logic [15:0] exp_addr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl [13];

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 16'((i * 40503) ^ 16'hA5A5);
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007;

    //             jmp  jaddr   rdy  v   out_pc   out_instr   rom_addr cnt
    tbl[0]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h00, rom[16'h00], 16'h01, 16'd0};
    tbl[1]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h01, rom[16'h01], 16'h02, 16'd1};
    tbl[2]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h02, rom[16'h02], 16'h03, 16'd2};
    tbl[3]  = '{1'b0, 16'h0,  1'b0, 1'b1, 16'h02, rom[16'h02], 16'h03, 16'd2};
    tbl[4]  = '{1'b0, 16'h0,  1'b0, 1'b1, 16'h02, rom[16'h02], 16'h03, 16'd2};
    tbl[5]  = '{1'b0, 16'h0,  1'b0, 1'b1, 16'h02, rom[16'h02], 16'h03, 16'd2};
    tbl[6]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h03, rom[16'h03], 16'h04, 16'd3};
    tbl[7]  = '{1'b1, 16'h10, 1'b0, 1'b0, 16'h03, rom[16'h03], 16'h10, 16'd3};
    tbl[8]  = '{1'b0, 16'h0,  1'b0, 1'b1, 16'h10, rom[16'h10], 16'h11, 16'd3};
    tbl[9]  = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h11, rom[16'h11], 16'h12, 16'd4};
    tbl[10] = '{1'b1, 16'h40, 1'b1, 1'b0, 16'h11, rom[16'h11], 16'h40, 16'd5};
    tbl[11] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h40, rom[16'h40], 16'h41, 16'd5};
    tbl[12] = '{1'b0, 16'h0,  1'b1, 1'b1, 16'h41, rom[16'h41], 16'h42, 16'd6};

    bus.jump_en = 1'b0; bus.jump_addr = '0; bus.out_ready = 1'b1;
    reset = 1'b1;
    do_reset();

    // Directed table: startup, stall, jump with and without consumption.
    for (int i = 0; i < 13; i++) begin
      cycle(tbl[i].jump, tbl[i].jaddr, tbl[i].ready);
      check($sformatf("tbl%0d.out_valid", i),   32'(bus.out_valid),   32'(tbl[i].exp_v));
      check($sformatf("tbl%0d.out_pc", i),      32'(bus.out_pc),      32'(tbl[i].exp_pc));
      check($sformatf("tbl%0d.out_instr", i),   32'(bus.out_instr),   32'(tbl[i].exp_ins));
      check($sformatf("tbl%0d.rom_addr", i),    32'(bus.rom_addr),    32'(tbl[i].exp_addr));
      check($sformatf("tbl%0d.fetch_count", i), 32'(bus.fetch_count), 32'(tbl[i].exp_cnt));
      check($sformatf("tbl%0d.fault", i),       32'(bus.fault),       32'h0);
    end

    // Mid-stream reset at pc=0x42, then restart from RESET_PC.
    do_reset();
    cycle(1'b0, 16'h0, 1'b1);
    check("restart.out_valid", 32'(bus.out_valid), 32'h1);
    check("restart.out_pc",    32'(bus.out_pc),    32'h0);
    check("restart.out_instr", 32'(bus.out_instr), 32'h0005);

    // Bounds edge: jump to the last populated word and run past it.
    do_reset();
    cycle(1'b1, 16'h00FF, 1'b1);
    check("bnd0.out_valid", 32'(bus.out_valid), 32'h0);
    check("bnd0.rom_addr",  32'(bus.rom_addr),  32'h00FF);
    cycle(1'b0, 16'h0, 1'b1);
    check("bnd1.out_valid", 32'(bus.out_valid), 32'h1);
    check("bnd1.out_pc",    32'(bus.out_pc),    32'h00FF);
    check("bnd1.fault",     32'(bus.fault),     32'h0);
    cycle(1'b0, 16'h0, 1'b1);
`ifdef FETCH_BOUNDS_EN
    check("bnd2.out_valid", 32'(bus.out_valid), 32'h0);
    check("bnd2.fault",     32'(bus.fault),     32'h1);
    check("bnd2.rom_addr",  32'(bus.rom_addr),  32'h0100);
`else
    check("bnd2.out_valid", 32'(bus.out_valid), 32'h1);
    check("bnd2.out_pc",    32'(bus.out_pc),    32'h0100);
    check("bnd2.fault",     32'(bus.fault),     32'h0);
`endif
    check("bnd2.fetch_count", 32'(bus.fetch_count), 32'd1);
    cycle(1'b1, 16'h0005, 1'b1);
`ifdef FETCH_BOUNDS_EN
    check("bnd3.rom_addr",  32'(bus.rom_addr),  32'h0100);
    check("bnd3.fault",     32'(bus.fault),     32'h1);
    check("bnd3.fetch_count", 32'(bus.fetch_count), 32'd1);
`else
    check("bnd3.rom_addr",  32'(bus.rom_addr),  32'h0005);
    check("bnd3.fault",     32'(bus.fault),     32'h0);
    check("bnd3.fetch_count", 32'(bus.fetch_count), 32'd2);
`endif
    check("bnd3.out_valid", 32'(bus.out_valid), 32'h0);

`ifndef FETCH_BOUNDS_EN
    // PC wrap at the top of the address space.
    cycle(1'b1, 16'hFFFF, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    check("wrap.out_pc",   32'(bus.out_pc),   32'hFFFF);
    check("wrap.rom_addr", 32'(bus.rom_addr), 32'h0000);
`endif
    check_model("post_directed");

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic        j, r;
      logic [15:0] ja;
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end
      j  = ($urandom_range(0, 7) == 0);
      ja = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF0 + $urandom_range(0, 15))
                                       : 16'($urandom_range(0, 299));
      r  = ($urandom_range(0, 3) != 0);
      cycle(j, ja, r);
      check_model($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
